// File: rtl/alu_rr_arbiter.sv
// Round-robin front end sharing one external 8-bit ALU; grant to rsp_valid is 2 cycles, one op in flight.
// Backpressure: rsp_ready low holds the response stable and blocks all req_ready until it is taken.
module alu_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [4*NREQ-1:0] req_op,
  output logic [7:0]        alu_bin1,
  output logic [7:0]        alu_bin2,
  output logic [3:0]        alu_opcode,
  input  logic [7:0]        alu_out,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_data,
  output logic              rsp_carry,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] next_ptr;
  logic           grant_vld;
  logic [IDW-1:0] grant_id;
  logic [7:0]     sel_a, sel_b;
  logic [3:0]     sel_op;

  // Scan from the highest offset down so the nearest requester at or after rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && (i == (int'(rr_ptr) + k) % NREQ)) begin
          grant_vld = 1'b1;
          grant_id  = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_id) begin
        sel_a  = req_a[8*i +: 8];
        sel_b  = req_b[8*i +: 8];
        sel_op = req_op[4*i +: 4];
      end
    end
  end

  assign next_ptr = (int'(rsp_id) == NREQ - 1) ? '0 : rsp_id + IDW'(1);

  // req_ready is gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d = EXEC;
          for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant_id) req_ready[i] = rst_n;
          end
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr     <= '0;
      alu_bin1   <= '0;
      alu_bin2   <= '0;
      alu_opcode <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_carry  <= 1'b0;
      rsp_id     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            alu_bin1   <= sel_a;
            alu_bin2   <= sel_b;
            alu_opcode <= sel_op;
            rsp_id     <= grant_id;
          end
        end
        EXEC: begin
          rsp_data  <= alu_out;
          // Carry is meaningful only for the add/sub families (0,1,8,9).
          rsp_carry <= alu_carry & (alu_opcode[2:1] == 2'b00);
          rsp_valid <= 1'b1;
          rr_ptr    <= next_ptr;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one 8-bit ALU (operands bin1/bin2, 4-bit opcode, 8-bit result plus carry) between NREQ requesters.
- Each requester has a valid/ready request channel. The block grants round-robin, drives the ALU from registered operands, captures result and carry, and returns them on one shared response channel tagged with the requester id.
- It sits between requester blocks and the combinational ALU. The ALU is instantiated next to it, not inside it.

Parameters:
- NREQ, 4, number of requesters; must be 2..8.
- IDW, 2, width of the id field; must be >= clog2(NREQ).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high.
- req_a  input  8*NREQ  operand A; slice i = [8i+7:8i].
- req_b  input  8*NREQ  operand B; slice i = [8i+7:8i].
- req_op  input  4*NREQ  ALU opcode; slice i = [4i+3:4i].
- alu_bin1  output  8  to ALU operand A.
- alu_bin2  output  8  to ALU operand B.
- alu_opcode  output  4  to ALU opcode.
- alu_out  input  8  ALU result.
- alu_carry  input  1  ALU carry.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_data  output  8  captured result.
- rsp_carry  output  1  captured carry, qualified.
- rsp_id  output  IDW  index of the requester served.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous), all registers clear:
  - State goes to IDLE; rr_ptr = 0.
  - alu_bin1 = alu_bin2 = 0; alu_opcode = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_carry = 0, rsp_id = 0.
  - req_ready = 0; busy = 0.
- States: IDLE, EXEC, RESP. Encoding is free.
- IDLE:
  - Search req_valid starting at index rr_ptr, ascending with wrap modulo NREQ. The first set bit is the grant g.
  - If any bit is set, req_ready[g] = 1 combinationally in this cycle only.
  - On the clock edge: latch req_a[g], req_b[g], req_op[g] into alu_bin1/alu_bin2/alu_opcode; latch g into rsp_id; go to EXEC.
  - With no valid bit set, stay in IDLE.
- Request handshake:
  - A transfer is valid & ready on the same edge.
  - A requester must hold valid and payload stable until ready. Dropping valid before ready is legal and simply withdraws the request.
- EXEC (one cycle):
  - ALU inputs are stable from registers.
  - On the edge: rsp_data <= alu_out; rsp_carry <= alu_carry & (alu_opcode[2:1] == 2'b00), i.e. carry only for the add/sub families (opcodes 0,1,8,9), otherwise 0.
  - rsp_valid <= 1; rr_ptr <= (g+1) mod NREQ; go to RESP.
- RESP:
  - rsp_valid = 1; rsp_data, rsp_carry and rsp_id are held stable.
  - When rsp_ready = 1 on an edge: rsp_valid <= 0, go to IDLE.
  - A new request is arbitrated in IDLE the following cycle. There is no overlap; throughput is 1 operation per 3 cycles minimum.
- Latency: request accepted at edge T gives rsp_valid high after edge T+1, i.e. visible in cycle T+2.
- req_ready is never asserted in EXEC or RESP.
- ALU output registers hold their last value outside EXEC; they are not cleared.
- Boundary conditions:
  - Simultaneous requests: served strictly round-robin. No requester waits more than NREQ-1 grants.
  - A single requester with valid held continuously is served back-to-back, every 3 cycles when rsp_ready = 1.
  - rr_ptr wraps from NREQ-1 to 0.
  - Reset asserted mid-EXEC or mid-RESP: the in-flight operation is dropped and outputs take reset values immediately, with no response issued.
  - rsp_ready high while rsp_valid is low has no effect.

Test Plan:
- Single ADD: requester 0 sends a=0xF0, b=0x20, op=0000. req_ready[0] is high the same cycle. Two cycles later: rsp_valid=1, rsp_data=0x10, rsp_carry=1, rsp_id=0.
- Carry masking: requester 1 sends a=0x0D, b=0xF1, op=0010 (AND). Response: rsp_data=0x01, rsp_carry=0, rsp_id=1.
- Round-robin: all 4 requesters valid from reset with rsp_ready=1. Grant order is 0,1,2,3,0. Responses arrive every 3 cycles with rsp_id in the same sequence.
- Pointer rotation: only requester 2 is valid and is served. Then requesters 0 and 3 go valid together; requester 3 is granted first, then 0.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP. Response fields stay constant, req_ready stays 0, busy=1. On release, IDLE follows the next cycle.
- Reset mid-operation: drop rst_n during EXEC. rsp_valid=0 and busy=0 immediately; after release, a pending request on requester 0 is granted first (rr_ptr=0).
